miriscv_decode_queue: RTL and testbench
=======================================

// Module: miriscv_decode_queue
// PURPOSE
// - Parametrised fetch->decode instruction queue for the next-gen miriscv pipeline.
// - Buffers {instr, current_pc, next_pc} from fetch and decouples it from decode by valid/ready.
// - Replaces the fixed 2-cycle boot-load shift register with a parametrised boot hold counter.
// - Flush (branch/jump kill) empties the queue in one cycle.
// PARAMETERS
// - DEPTH        4   entries; power of two, >= 2
// - XLEN         32  PC width
// - ILEN         32  instruction width
// - BOOT_CYCLES  2   cycles after reset release with queue closed; 0 = open immediately
// PORTS
// - clk_i           in   1             clock
// - arstn_i         in   1             reset; asynchronous, active-low
// - f_instr_i       in   ILEN          instruction from fetch
// - f_current_pc_i  in   XLEN          PC of f_instr_i
// - f_next_pc_i     in   XLEN          sequential next PC
// - f_valid_i       in   1             fetch offers an entry
// - f_ready_o       out  1             queue accepts an entry
// - d_instr_o       out  ILEN          head instruction to decode
// - d_current_pc_o  out  XLEN          head PC
// - d_next_pc_o     out  XLEN          head next PC
// - d_valid_o       out  1             head entry valid
// - d_ready_i       in   1             decode consumes head (low = decode stall)
// - flush_i         in   1             kill all entries (cu_kill_f)
// - boot_done_o     out  1             boot hold elapsed
// - count_o         out  $clog2(DEPTH+1)  occupancy
// - full_o          out  1             count_o == DEPTH
// - empty_o         out  1             count_o == 0
// BEHAVIOUR
// - Reset (async, arstn_i low): wr_ptr, rd_ptr, count, boot counter and storage -> 0.
//   Outputs: f_ready_o=0, d_valid_o=0, d_* = 0, count_o=0, full_o=0, empty_o=1.
//   boot_done_o=0, or 1 if BOOT_CYCLES=0.
// - Boot counter: increments each cycle after reset release and saturates at BOOT_CYCLES.
//   boot_done_o = (counter == BOOT_CYCLES).
// - f_ready_o = boot_done_o & ~full_o & ~flush_i.
// - d_valid_o = boot_done_o & ~empty_o & ~flush_i.
// - push = f_valid_i & f_ready_o: write storage at wr_ptr, wr_ptr++.
// - pop = d_valid_o & d_ready_i: rd_ptr++.
// - Pointers are $clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
// - count: +1 on push only, -1 on pop only, unchanged on push&pop.
//   count never exceeds DEPTH and never goes below 0.
// - Full: f_ready_o=0 even if a pop occurs that cycle (no same-cycle refill; timing decision).
// - Empty: d_valid_o=0, so no pop is possible.
// - d_* = storage[rd_ptr] when d_valid_o=1, else forced to 0.
// - Latency without bypass: push in cycle N -> d_valid_o=1 in cycle N+1. Throughput 1/cycle.
// - flush_i=1: push and pop both blocked that cycle.
//   Next cycle: wr_ptr=rd_ptr=0, count=0. Storage contents are not cleared.
//   Flush during boot hold has no effect on the boot counter.
// - Reset mid-operation: immediate return to reset values; boot hold reruns on release.
// CONFIGURATION
// - Macro MIRISCV_DQ_BYPASS_EN: defined -> fall-through path.
//   - When the queue is empty, boot_done_o=1, flush_i=0 and f_valid_i=1:
//     d_valid_o=1 and d_* = f_* combinationally.
//   - If d_ready_i=1 that cycle, the entry is consumed without being written and count stays 0.
//   - Otherwise the entry is pushed normally.
//   - f_ready_o is unchanged by the macro.
// - Macro undefined: no comb path from f_* to d_*; latency is exactly 1 cycle.
// TESTING
// - Boot, BOOT_CYCLES=2, f_valid_i=1 held from reset release:
//   f_ready_o=0 and boot_done_o=0 in cycles 0-1; both =1 in cycle 2; first push in cycle 2.
// - Fill, DEPTH=4, d_ready_i=0, push PCs 0x0,0x4,0x8,0xC:
//   count_o=4, full_o=1, f_ready_o=0.
//   Then d_ready_i=1: d_current_pc_o = 0x0,0x4,0x8,0xC on consecutive cycles, then empty_o=1.
// - Wrap, simultaneous push/pop for 10 cycles at count 2:
//   count_o stays 2, PCs emerge in order, pointers wrap twice.
// - Flush at count 3 with f_valid_i=1:
//   f_ready_o=0 that cycle; next cycle count_o=0, empty_o=1, d_valid_o=0.
// - Reset mid-run: arstn_i low with count 2 -> d_valid_o=0 and count_o=0 without a clock edge.
//   After release, the boot hold reruns.
// - Bypass, macro on, empty queue, push instr 0x00000013 with d_ready_i=1:
//   d_valid_o=1 same cycle and count_o stays 0.
//   Macro off: d_valid_o=1 the next cycle.

Source files
------------

// File: rtl/miriscv_decode_queue.sv
// Fetch->decode instruction queue with boot hold counter and one-cycle flush.
// Optional fall-through path when empty: define MIRISCV_DQ_BYPASS_EN.
module miriscv_decode_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ILEN        = 32,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic [ILEN-1:0]            f_instr_i,
  input  logic [XLEN-1:0]            f_current_pc_i,
  input  logic [XLEN-1:0]            f_next_pc_i,
  input  logic                       f_valid_i,
  output logic                       f_ready_o,
  output logic [ILEN-1:0]            d_instr_o,
  output logic [XLEN-1:0]            d_current_pc_o,
  output logic [XLEN-1:0]            d_next_pc_o,
  output logic                       d_valid_o,
  input  logic                       d_ready_i,
  input  logic                       flush_i,
  output logic                       boot_done_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
  localparam int unsigned EW = ILEN + 2 * XLEN;

  localparam logic [BW-1:0] BOOT_MAX = BW'(BOOT_CYCLES);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [BW-1:0] boot_cnt;

  logic          boot_done;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          byp;
  logic          mem_push;
  logic          mem_pop;
  logic [EW-1:0] f_entry;
  logic [EW-1:0] head;

  assign f_entry   = {f_instr_i, f_current_pc_i, f_next_pc_i};
  assign boot_done = (boot_cnt == BOOT_MAX);
  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);

  assign f_ready_o = boot_done & ~full & ~flush_i;
  assign push      = f_valid_i & f_ready_o;

`ifdef MIRISCV_DQ_BYPASS_EN
  // When empty, the head is the fetch entry itself; it is only stored if decode stalls.
  assign byp       = boot_done & empty & ~flush_i & f_valid_i;
  assign d_valid_o = boot_done & ~flush_i & (~empty | f_valid_i);
  assign head      = empty ? f_entry : mem[rd_ptr];
`else
  assign byp       = 1'b0;
  assign d_valid_o = boot_done & ~empty & ~flush_i;
  assign head      = mem[rd_ptr];
`endif

  assign pop      = d_valid_o & d_ready_i;
  assign mem_push = push & ~(byp & d_ready_i);
  assign mem_pop  = pop & ~byp;

  assign {d_instr_o, d_current_pc_o, d_next_pc_o} = d_valid_o ? head : '0;

  assign boot_done_o = boot_done;
  assign count_o     = count;
  assign full_o      = full;
  assign empty_o     = empty;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      boot_cnt <= '0;
    end else if (!boot_done) begin
      boot_cnt <= boot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (mem_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (mem_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({mem_push, mem_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_push) begin
      mem[wr_ptr] <= f_entry;
    end
  end

endmodule

// File: tb/tb_miriscv_decode_queue.sv
// Scoreboard bench for miriscv_decode_queue: queue-based reference model plus
// an independent monitor that checks every entry handed to decode.
module tb_miriscv_decode_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned BOOT  = 2;
`ifdef MIRISCV_DQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
  } entry_t;

  logic            clk = 1'b0;
  logic            arstn;
  logic [ILEN-1:0] f_instr;
  logic [XLEN-1:0] f_pc;
  logic [XLEN-1:0] f_npc;
  logic            f_valid;
  logic            f_ready;
  logic [ILEN-1:0] d_instr;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_npc;
  logic            d_valid;
  logic            d_ready;
  logic            flush;
  logic            boot_done;
  logic [2:0]      count;
  logic            full;
  logic            empty;

  entry_t          sb[$];
  int              checks   = 0;
  int              failures = 0;
  int unsigned     boot_edges;
  logic [XLEN-1:0] pc_ctr = '0;

  miriscv_decode_queue #(
    .DEPTH      (DEPTH),
    .XLEN       (XLEN),
    .ILEN       (ILEN),
    .BOOT_CYCLES(BOOT)
  ) dut (
    .clk_i         (clk),
    .arstn_i       (arstn),
    .f_instr_i     (f_instr),
    .f_current_pc_i(f_pc),
    .f_next_pc_i   (f_npc),
    .f_valid_i     (f_valid),
    .f_ready_o     (f_ready),
    .d_instr_o     (d_instr),
    .d_current_pc_o(d_pc),
    .d_next_pc_o   (d_npc),
    .d_valid_o     (d_valid),
    .d_ready_i     (d_ready),
    .flush_i       (flush),
    .boot_done_o   (boot_done),
    .count_o       (count),
    .full_o        (full),
    .empty_o       (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Boot hold reference: rising edges seen since reset release.
  always @(posedge clk or negedge arstn) begin
    if (!arstn) boot_edges <= 0;
    else if (boot_edges < BOOT) boot_edges <= boot_edges + 1;
  end

  // Reference model: occupancy is the scoreboard length; handshakes follow the rules directly.
  always @(negedge clk) begin : model
    bit bd;
    bit exp_fr;
    bit exp_dv;
    int n;
    if (!arstn) begin
      sb.delete();
    end else begin
      n      = sb.size();
      bd     = (boot_edges >= BOOT);
      exp_fr = bd && (n < DEPTH) && !flush;
      exp_dv = bd && !flush && ((n > 0) || (BYP && f_valid));
      chk("boot_done", 96'(boot_done), 96'(bd));
      chk("f_ready", 96'(f_ready), 96'(exp_fr));
      chk("d_valid", 96'(d_valid), 96'(exp_dv));
      chk("count", 96'(count), 96'(n));
      chk("full", 96'(full), 96'(n == DEPTH));
      chk("empty", 96'(empty), 96'(n == 0));
      if (!exp_dv) chk("d_zero", {d_instr, d_pc, d_npc}, '0);
      if (flush) begin
        sb.delete();
      end else if (f_valid && exp_fr) begin
        sb.push_back('{instr: f_instr, pc: f_pc, npc: f_npc});
        pc_ctr <= pc_ctr + 32'd4;
      end
    end
  end

  // Monitor: every entry consumed by decode must be the oldest accepted one.
  always @(negedge clk) begin : monitor
    entry_t e;
    #1;
    if (arstn && d_valid && d_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_underflow actual=pop required=no_pop at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("d_entry", {d_instr, d_pc, d_npc}, e);
      end
    end
  end

  task automatic set_in(input bit fv, input bit dr, input bit fl);
    f_valid = fv;
    d_ready = dr;
    flush   = fl;
    f_instr = (pc_ctr == '0) ? 32'h0000_0013 : $urandom;
    f_pc    = pc_ctr;
    f_npc   = pc_ctr + 32'd4;
  endtask

  task automatic drive(input bit fv, input bit dr, input bit fl);
    @(posedge clk);
    #1;
    set_in(fv, dr, fl);
  endtask

  task automatic random_run(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end
  endtask

  initial begin
    arstn = 1'b0;
    set_in(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d_valid", 96'(d_valid), 96'(0));
    chk("rst_f_ready", 96'(f_ready), 96'(0));
    chk("rst_count", 96'(count), 96'(0));
    chk("rst_full", 96'(full), 96'(0));
    chk("rst_empty", 96'(empty), 96'(1));
    chk("rst_boot_done", 96'(boot_done), 96'(0));
    chk("rst_d_data", {d_instr, d_pc, d_npc}, '0);

    // Release with fetch already offering; boot hold then fill to full.
    @(posedge clk);
    #1;
    arstn = 1'b1;
    set_in(1'b1, 1'b0, 1'b0);
    repeat (6) drive(1'b1, 1'b0, 1'b0);
    repeat (6) drive(1'b0, 1'b1, 1'b0);

    // Steady push/pop at occupancy 2 so pointers wrap.
    repeat (2) drive(1'b1, 1'b0, 1'b0);
    repeat (10) drive(1'b1, 1'b1, 1'b0);

    // Flush at occupancy 3 with fetch still offering.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    // Empty queue, single entry offered with decode ready.
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);

    random_run(400);

    // Asynchronous reset mid-run with entries held.
    repeat (3) drive(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    arstn = 1'b0;
    #1;
    chk("midrst_d_valid", 96'(d_valid), 96'(0));
    chk("midrst_count", 96'(count), 96'(0));
    chk("midrst_empty", 96'(empty), 96'(1));
    chk("midrst_boot_done", 96'(boot_done), 96'(0));
    repeat (2) @(posedge clk);
    #1;
    arstn = 1'b1;
    set_in(1'b1, 1'b1, 1'b0);

    random_run(200);
    repeat (8) drive(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
